// File: rtl/game_screen_ctrl.sv
// Screen/score controller for the IR-driven snake game: sequences IDLE/PLAY/PAUSE/OVER,
// double-buffers the game grid into tear-free frames and keeps BCD score and best score.
module game_screen_ctrl #(
   parameter int                   ROWS        = 16,
   parameter int                   COLS        = 16,
   parameter int                   LEN_W       = 8,
   parameter int                   SCORE_MULT  = 5,
   parameter int                   DIGITS      = 4,
   parameter logic [31:0]          CMD_START   = 32'h20DFEA15,
   parameter logic [31:0]          CMD_PAUSE   = 32'h20DF22DD,
   parameter logic [31:0]          CMD_RESTART = 32'h20DF6A95,
   parameter logic [ROWS*COLS-1:0] START_PAT   = '0,
   parameter logic [ROWS*COLS-1:0] END_PAT     = '0
) (
   input  logic                       CLOCK_50,
   input  logic                       reset_n,
   input  logic [31:0]                cmd_word,
   input  logic                       cmd_valid,
   input  logic                       game_over,
   input  logic [LEN_W-1:0]           length,
   input  logic [COLS-1:0]            row_data,
   output logic [$clog2(ROWS)-1:0]    row_sel,
   output logic [ROWS*COLS-1:0]       disp_grid,
   output logic                       frame_valid,
   output logic                       game_run,
   output logic [1:0]                 state,
   output logic [4*DIGITS-1:0]        score_bcd,
   output logic [4*DIGITS-1:0]        hiscore_bcd
);

   localparam int RS_W      = $clog2(ROWS);
   localparam int BCD_W     = 4 * DIGITS;
   localparam int SCORE_MAX = 10**DIGITS - 1;
   localparam int BIN_W     = $clog2(SCORE_MAX + 1);
   localparam int MULT_W    = (SCORE_MULT < 1) ? 1 : $clog2(SCORE_MULT + 1);
   localparam int PROD_W    = LEN_W + MULT_W;
   localparam int CMP_W     = (PROD_W > BIN_W) ? PROD_W : BIN_W;
   localparam int CNT_W     = $clog2(BIN_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   logic is_start, is_pause, is_restart;
   logic [1:0] nxt;
   logic load_start, load_end, publish;

   assign is_start   = cmd_valid && (cmd_word == CMD_START);
   assign is_pause   = cmd_valid && (cmd_word == CMD_PAUSE);
   assign is_restart = cmd_valid && (cmd_word == CMD_RESTART);

   // NOTE: assign a default before the case so every path drives nxt and no latch is inferred.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (is_start) nxt = S_PLAY;
         S_PLAY:  if (game_over) nxt = S_OVER;
                  else if (is_restart) nxt = S_IDLE;
                  else if (is_pause) nxt = S_PAUSE;
         S_PAUSE: if (is_restart) nxt = S_IDLE;
                  else if (is_pause) nxt = S_PLAY;
         default: if (is_restart) nxt = S_IDLE;
      endcase
   end

   assign load_start = (nxt != state) && (nxt == S_IDLE);
   assign load_end   = (nxt != state) && (nxt == S_OVER);
   assign game_run   = (state == S_PLAY);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= nxt;
   end

   // Row scan and shadow capture; row_data lags row_sel by one cycle.
   logic [RS_W-1:0]      row_sel_d;
   logic                 cap_valid;
   logic                 armed;
   logic [ROWS*COLS-1:0] shadow;
   logic [ROWS*COLS-1:0] frame_next;

   // NOTE: the shadow buffer is reset so a reset mid-frame can never leak stale rows.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         row_sel   <= '0;
         row_sel_d <= '0;
         cap_valid <= 1'b0;
         armed     <= 1'b0;
         shadow    <= '0;
      end else begin
         row_sel   <= (row_sel == RS_W'(ROWS - 1)) ? '0 : row_sel + 1'b1;
         row_sel_d <= row_sel;
         cap_valid <= 1'b1;
         if (cap_valid)
            shadow[int'(row_sel_d)*COLS +: COLS] <= row_data;
         if (state == S_IDLE || state == S_OVER)
            armed <= 1'b0;
         else if (state == S_PLAY && cap_valid && row_sel_d == '0)
            armed <= 1'b1;
      end
   end

   // The last row arrives on the publishing edge itself, so merge it straight from row_data.
   always_comb begin
      frame_next = shadow;
      frame_next[(ROWS-1)*COLS +: COLS] = row_data;
   end

   assign publish = (state == S_PLAY) && (nxt == S_PLAY) && cap_valid && armed &&
                    (row_sel_d == RS_W'(ROWS - 1));

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         disp_grid   <= START_PAT;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (load_start) begin
            disp_grid   <= START_PAT;
            frame_valid <= 1'b1;
         end else if (load_end) begin
            disp_grid   <= END_PAT;
            frame_valid <= 1'b1;
         end else if (publish) begin
            disp_grid   <= frame_next;
            frame_valid <= 1'b1;
         end
      end
   end

   // Score: saturated product, then serial double-dabble skipping leading zero bits.
   logic [CMP_W-1:0] prod;
   logic [BIN_W-1:0] raw, raw_q, raw_aligned, bin_sh;
   logic [CNT_W-1:0] nbits, bit_cnt;
   logic [BCD_W-1:0] bcd_acc, bcd_step;
   logic             busy;

   assign prod = CMP_W'(length) * CMP_W'(SCORE_MULT);
   assign raw  = (prod > CMP_W'(SCORE_MAX)) ? BIN_W'(SCORE_MAX) : BIN_W'(prod);

   always_comb begin
      nbits = '0;
      for (int i = 0; i < BIN_W; i++)
         if (raw[i]) nbits = CNT_W'(i + 1);
   end

   assign raw_aligned = raw << (CNT_W'(BIN_W) - nbits);

   function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
      logic [BCD_W-1:0] t;
      t = b;
      for (int d = 0; d < DIGITS; d++)
         if (t[4*d +: 4] >= 4'd5) t[4*d +: 4] = t[4*d +: 4] + 4'd3;
      return {t[BCD_W-2:0], bit_in};
   endfunction

   assign bcd_step = dabble(bcd_acc, bin_sh[BIN_W-1]);

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         raw_q     <= '0;
         bin_sh    <= '0;
         bcd_acc   <= '0;
         bit_cnt   <= '0;
         busy      <= 1'b0;
         score_bcd <= '0;
      end else if (raw != raw_q) begin
         raw_q   <= raw;
         bin_sh  <= raw_aligned;
         bcd_acc <= '0;
         bit_cnt <= nbits;
         busy    <= (nbits != '0);
         if (nbits == '0) score_bcd <= '0;
      end else if (busy) begin
         bcd_acc <= bcd_step;
         bin_sh  <= bin_sh << 1;
         bit_cnt <= bit_cnt - 1'b1;
         if (bit_cnt == CNT_W'(1)) begin
            busy      <= 1'b0;
            score_bcd <= bcd_step;
         end
      end
   end

   // BCD digits compare correctly as plain unsigned values.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n)
         hiscore_bcd <= '0;
      else if (load_end && score_bcd > hiscore_bcd)
         hiscore_bcd <= score_bcd;
   end

endmodule
